// File: rtl/rr_arb_mux_4_1.sv
// Round-robin 4:1 arbiter feeding one registered output word; 1 clk from input transfer to out_valid.
// Stalls (in_ready=0) while the held word is not drained; RR_ARB_MUX_STATS_EN adds saturating per-requester grant counters.
module rr_arb_mux_4_1 #(
  parameter int WIDTH = 4
`ifdef RR_ARB_MUX_STATS_EN
  , parameter int CNT_W = 8
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       in_valid,
  input  logic [WIDTH-1:0] in_data0,
  input  logic [WIDTH-1:0] in_data1,
  input  logic [WIDTH-1:0] in_data2,
  input  logic [WIDTH-1:0] in_data3,
  output logic [3:0]       in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_sel,
  input  logic             out_ready
`ifdef RR_ARB_MUX_STATS_EN
  , output logic [4*CNT_W-1:0] grant_cnt
`endif
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [1:0]       out_sel_q, out_sel_d;
  logic [1:0]       ptr_q, ptr_d;

  logic             load;
  logic [3:0]       grant;
  logic             grant_any;
  logic [1:0]       grant_idx;
  logic [1:0]       scan_idx;
  logic [WIDTH-1:0] in_data_arr [4];

  assign in_data_arr[0] = in_data0;
  assign in_data_arr[1] = in_data1;
  assign in_data_arr[2] = in_data2;
  assign in_data_arr[3] = in_data3;

  // Scan starts one past the last winner; the 2-bit add wraps naturally.
  always_comb begin
    load      = !out_valid_q || out_ready;
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = ptr_q;
    scan_idx  = ptr_q;
    for (int k = 1; k <= 4; k++) begin
      scan_idx = ptr_q + 2'(k);
      if (!grant_any && in_valid[scan_idx]) begin
        grant_any = 1'b1;
        grant_idx = scan_idx;
      end
    end
    if (!load || rst) begin
      grant_any = 1'b0;
    end
    if (grant_any) begin
      grant[grant_idx] = 1'b1;
    end
    in_ready = grant;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
    if (load) begin
      if (grant_any) begin
        out_valid_d = 1'b1;
        out_data_d  = in_data_arr[grant_idx];
        out_sel_d   = grant_idx;
        ptr_d       = grant_idx;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  // ptr resets to 3 so requester 0 is scanned first.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= 2'd0;
      ptr_q       <= 2'd3;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

`ifdef RR_ARB_MUX_STATS_EN
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
      if (in_valid[i] && in_ready[i] && !(&cnt_q[i])) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        cnt_q[i] <= '0;
      end else begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      grant_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_rr_arb_mux_4_1.sv
// Bench for rr_arb_mux_4_1: directed scenarios plus randomized traffic against a behavioural model.
module tb_rr_arb_mux_4_1;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in_valid;
  logic [3:0] din [4];
  logic [3:0] in_ready;
  logic       out_valid;
  logic [3:0] out_data;
  logic [1:0] out_sel;
  logic       out_ready;
`ifdef RR_ARB_MUX_STATS_EN
  logic [7:0] grant_cnt;
`endif

  int tests = 0;
  int fails = 0;

  // behavioural model of the output register and round-robin history
  logic       m_vld;
  logic [3:0] m_dat;
  int         m_sel;
  int         m_last;
  int         m_cnt [4];
  int         last_grant;

  rr_arb_mux_4_1 #(
    .WIDTH(4)
`ifdef RR_ARB_MUX_STATS_EN
    , .CNT_W(2)
`endif
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .in_data0(din[0]), .in_data1(din[1]), .in_data2(din[2]), .in_data3(din[3]),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_sel(out_sel), .out_ready(out_ready)
`ifdef RR_ARB_MUX_STATS_EN
    , .grant_cnt(grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic int pick(input logic [3:0] v, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (v[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  // One clock: drive, check grant mid-cycle, advance model, check register after edge.
  task automatic step(input logic r, input logic [3:0] v, input logic ordy);
    logic [3:0] exp_g;
    int g;
    rst = r; in_valid = v; out_ready = ordy;
    @(negedge clk);
    exp_g = 4'b0;
    g = -1;
    if (!r && (!m_vld || ordy)) g = pick(v, m_last);
    if (g >= 0) exp_g[g] = 1'b1;
    tests++;
    if (in_ready !== exp_g) begin
      fails++;
      $display("FAIL in_ready: got %b expected %b (t=%0t)", in_ready, exp_g, $time);
    end
    if (r) begin
      m_vld = 1'b0; m_dat = 4'd0; m_sel = 0; m_last = 3;
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    end else if (!m_vld || ordy) begin
      if (g >= 0) begin
        m_vld = 1'b1; m_dat = din[g]; m_sel = g; m_last = g;
        if (m_cnt[g] < 3) m_cnt[g]++;
      end else begin
        m_vld = 1'b0;
      end
    end
    last_grant = g;
    @(posedge clk);
    #1;
    tests++;
    if (out_valid !== m_vld || out_data !== m_dat || out_sel !== 2'(m_sel)) begin
      fails++;
      $display("FAIL out_reg: got v=%b d=%0h s=%0d expected v=%b d=%0h s=%0d (t=%0t)",
               out_valid, out_data, out_sel, m_vld, m_dat, m_sel, $time);
    end
`ifdef RR_ARB_MUX_STATS_EN
    tests++;
    for (int i = 0; i < 4; i++) begin
      if (grant_cnt[i*2 +: 2] !== 2'(m_cnt[i])) begin
        fails++;
        $display("FAIL grant_cnt[%0d]: got %0d expected %0d", i, grant_cnt[i*2 +: 2], m_cnt[i]);
      end
    end
`endif
  endtask

  task automatic test_reset;
    din[0] = 4'hA; din[1] = 4'hB; din[2] = 4'hC; din[3] = 4'hD;
    step(1'b1, 4'b1111, 1'b1);
    step(1'b1, 4'b1111, 1'b1);
    tests++;
    if (out_valid !== 1'b0 || out_data !== 4'd0 || out_sel !== 2'd0) begin
      fails++;
      $display("FAIL reset_state: got v=%b d=%0h s=%0d expected 0/0/0", out_valid, out_data, out_sel);
    end
  endtask

  task automatic test_round_robin;
    int exp_seq [5] = '{0, 1, 2, 3, 0};
    logic [3:0] exp_dat [5] = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hA};
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 4'b1111, 1'b1);
      tests++;
      if (out_valid !== 1'b1 || out_sel !== 2'(exp_seq[k]) || out_data !== exp_dat[k]) begin
        fails++;
        $display("FAIL rr_seq[%0d]: got v=%b s=%0d d=%0h expected 1 s=%0d d=%0h",
                 k, out_valid, out_sel, out_data, exp_seq[k], exp_dat[k]);
      end
    end
  endtask

  task automatic test_single;
    din[2] = 4'd7;
    step(1'b0, 4'b0100, 1'b1);
    tests++;
    if (out_valid !== 1'b1 || out_data !== 4'd7 || out_sel !== 2'd2) begin
      fails++;
      $display("FAIL single: got v=%b d=%0d s=%0d expected 1/7/2", out_valid, out_data, out_sel);
    end
    step(1'b0, 4'b0000, 1'b1);
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL idle_drop: got out_valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_stall;
    din[0] = 4'd5; din[1] = 4'd3;
    step(1'b0, 4'b0001, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 4'b0010, 1'b0);
      tests++;
      if (out_data !== 4'd5 || out_sel !== 2'd0 || in_ready !== 4'b0000) begin
        fails++;
        $display("FAIL stall[%0d]: got d=%0d s=%0d rdy=%b expected 5/0/0000", k, out_data, out_sel, in_ready);
      end
    end
    step(1'b0, 4'b0010, 1'b1);
    tests++;
    if (out_valid !== 1'b1 || out_data !== 4'd3 || out_sel !== 2'd1) begin
      fails++;
      $display("FAIL drain_fill: got v=%b d=%0d s=%0d expected 1/3/1", out_valid, out_data, out_sel);
    end
  endtask

  task automatic test_wrap;
    din[0] = 4'hE; din[1] = 4'h1;
    step(1'b0, 4'b0010, 1'b1);
    rst = 1'b0; in_valid = 4'b0011; out_ready = 1'b1;
    #2;
    tests++;
    if (in_ready !== 4'b0001) begin
      fails++;
      $display("FAIL wrap_grant: got %b expected 0001", in_ready);
    end
    step(1'b0, 4'b0011, 1'b1);
  endtask

  task automatic test_reset_mid;
    din[2] = 4'd9;
    step(1'b0, 4'b0100, 1'b1);
    step(1'b1, 4'b1111, 1'b0);
    tests++;
    if (out_valid !== 1'b0 || out_data !== 4'd0 || out_sel !== 2'd0) begin
      fails++;
      $display("FAIL reset_mid: got v=%b d=%0d s=%0d expected 0/0/0", out_valid, out_data, out_sel);
    end
    din[0] = 4'h6; din[3] = 4'h8;
    step(1'b0, 4'b1001, 1'b1);
    tests++;
    if (out_sel !== 2'd0 || out_data !== 4'h6) begin
      fails++;
      $display("FAIL post_reset_grant: got s=%0d d=%0h expected 0/6", out_sel, out_data);
    end
  endtask

  // Requesters hold valid/data until accepted; track waits for the fairness bound.
  task automatic test_random;
    logic [3:0] pend = 4'b0;
    int waits [4] = '{0, 0, 0, 0};
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
          pend[i] = 1'b1;
          din[i] = 4'($urandom_range(0, 15));
        end
      end
      step(1'b0, pend, ($urandom_range(0, 9) < 7));
      if (last_grant >= 0) begin
        tests++;
        if (waits[last_grant] > 3) begin
          fails++;
          $display("FAIL fairness: requester %0d waited %0d transfers, limit 3", last_grant, waits[last_grant]);
        end
        for (int i = 0; i < 4; i++) begin
          if (i == last_grant) waits[i] = 0;
          else if (pend[i]) waits[i]++;
        end
        pend[last_grant] = 1'b0;
      end
    end
  endtask

  task automatic test_stats_saturate;
    step(1'b1, 4'b0000, 1'b1);
    for (int k = 0; k < 5; k++) begin
      din[3] = 4'(k);
      step(1'b0, 4'b1000, 1'b1);
    end
`ifdef RR_ARB_MUX_STATS_EN
    tests++;
    if (grant_cnt !== 8'b11_00_00_00) begin
      fails++;
      $display("FAIL stats_sat: got %b expected 11000000", grant_cnt);
    end
`endif
  endtask

  initial begin
    rst = 1'b1; in_valid = 4'b0; out_ready = 1'b0;
    m_vld = 1'b0; m_dat = 4'd0; m_sel = 0; m_last = 3; last_grant = -1;
    for (int i = 0; i < 4; i++) begin
      din[i] = 4'd0;
      m_cnt[i] = 0;
    end
    test_reset;
    test_round_robin;
    test_single;
    test_stall;
    test_wrap;
    test_reset_mid;
    test_random;
    test_stats_saturate;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
